spectrum_scandoubler: RTL and testbench
=======================================

// Module: spectrum_scandoubler
// PURPOSE
//  Line doubler downstream of the video controller: takes 15 kHz RGB333 + syncs at 7 MHz pixel rate,
//  emits each line twice at 14 MHz pixel rate (31 kHz) for VGA. Two-line ping-pong buffer; input line
//  length and hsync width measured per line, so 448/456-pixel lines (Pentagon/48K/128K) need no mode pins.
// PARAMETERS
//  HLEN_MAX   512  line-buffer depth per bank, pixels (power of 2); pixels at index >= HLEN_MAX dropped
//  CNT_W      10   width of line/sync counters; counters saturate at 2**CNT_W-1
// PORTS
//  clk_sys    in   1   master clock
//  reset      in   1   synchronous, active-high
//  ce_pix     in   1   input pixel enable (7 MHz); always coincides with a ce_pix2x pulse
//  ce_pix2x   in   1   output pixel enable (14 MHz)
//  hs_in      in   1   input hsync, active-high
//  vs_in      in   1   input vsync, active-high
//  hblank_in  in   1   input hblank; blanked pixels stored as 0
//  r_in,g_in,b_in in 3 each  input colour
//  scanlines  in   1   dim second copy of each line (see CONFIGURATION)
//  hs_out     out  1   output hsync, active-high
//  vs_out     out  1   output vsync, active-high
//  r_out,g_out,b_out out 3 each  output colour
// BEHAVIOUR
//  Reset: all outputs 0; hcnt_in=hcnt_out=0; hlen=448; hs_w=32; bank=0; line_odd=0.
//  Input side (on ce_pix only):
//   - hs_rise = hs_in & ~hs_in_d (hs_in_d updated on ce_pix).
//   - hs_rise: hlen<=hcnt_in+1 (clamped to 2**CNT_W-1), hcnt_in<=0, bank<=~bank; else hcnt_in+1, saturating.
//   - hs_fall: hs_w<=hcnt_in+1 (hsync width in input pixels, counted from rise).
//   - write buf[bank][hcnt_in] <= hblank_in ? 0 : {r,g,b} when hcnt_in < HLEN_MAX; write uses
//     pre-update bank/hcnt_in, so the pixel coincident with hs_rise is the last of the old line.
//  Output side (on ce_pix2x only):
//   - hcnt_out counts 0..hlen-1, wraps to 0 toggling line_odd; forced to 0, line_odd<=0 on the
//     ce_pix2x coincident with hs_rise (input wins over wrap when simultaneous).
//   - read address buf[~bank][hcnt_out]; read data registered: colour outputs lag hcnt_out by exactly
//     1 ce_pix2x. Address >= HLEN_MAX reads as 0.
//   - hs_out registered from (hcnt_out < hs_w) with same 1-cycle lag, so sync aligns with pixels;
//     duration halves in time, i.e. hs_w output pixels each of the two output lines.
//   - vs_out <= vs_in sampled when hcnt_out==0 (changes only at output line start).
//  Boundaries: no hs for >2**CNT_W-1 pixels -> hcnt_in saturates, writes stop, output keeps
//  repeating last hlen. hlen < hs_w -> hs_out held high whole line (no special case).
//  First line after reset reads uninitialised bank; content undefined, syncs valid.
//  Reset mid-line: all state returns to reset values on the same cycle; buffer RAM not cleared.
//  Buffer: 2*HLEN_MAX x 9 bit, one write + one read port, infers block RAM.
// CONFIGURATION
//  SCANDBL_SCANLINES_EN defined: when scanlines=1 and line_odd=1 each colour channel output as
//   value>>1 (e.g. 3'b111 -> 3'b011); line_odd=0 lines unchanged. scanlines sampled at hcnt_out==0.
//  Not defined: scanlines port present but ignored; both copies identical; no dimming logic.
// TESTING
//  1 448-pixel lines, hs 32 px wide, pixel n colour = n[8:0] -> after 2 lines hlen=448, hs_w=32;
//    each input line appears twice, out pixel k = k[8:0], hs_out high for out counts 1..32 (1-cycle lag).
//  2 switch to 456-pixel lines mid-stream -> hlen=456 after first hs_rise, no dropped/duplicated
//    output pixel after that line; hcnt_out resets on every hs_rise.
//  3 hblank_in high for counts 312..419 -> those output pixels read 0 on both copies.
//  4 hs_in held low 1500 ce_pix -> hcnt_in stops at 1023, output repeats at last hlen, no X.
//  5 SCANDBL_SCANLINES_EN, scanlines=1, input white 3'b111 -> first copy 3'b111, second 3'b011;
//    build without macro -> both 3'b111.
//  6 reset asserted at hcnt_in=200 for 1 cycle -> next cycle all outputs 0, hlen=448, hs_w=32,
//    bank=0; vs_in pulse 4 lines -> vs_out 8 output lines, edges at hcnt_out==0.

Source files
------------

// File: rtl/spectrum_scandoubler.sv
// 15 kHz -> 31 kHz line doubler: each input line is captured into one bank of a ping-pong buffer
// and replayed twice from the other bank. Optional scanline dimming: define SCANDBL_SCANLINES_EN.
module spectrum_scandoubler #(
  parameter int HLEN_MAX = 512,
  parameter int CNT_W    = 10
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       ce_pix2x,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       hblank_in,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [2:0] b_in,
  input  logic       scanlines,
  output logic       hs_out,
  output logic       vs_out,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [2:0] b_out
);

  localparam int AW = $clog2(HLEN_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BUF_LEN   = CNT_W'(HLEN_MAX);
  localparam logic [CNT_W-1:0] HLEN_RST  = CNT_W'(448);
  localparam logic [CNT_W-1:0] HSW_RST   = CNT_W'(32);

  logic             hs_in_d;
  logic [CNT_W-1:0] hcnt_in;
  logic [CNT_W-1:0] hcnt_in_inc;
  logic [CNT_W-1:0] hlen;
  logic [CNT_W-1:0] hs_w;
  logic [CNT_W-1:0] hcnt_out;
  logic             bank;
  logic             line_odd;
  logic             hs_rise;
  logic             hs_fall;
  logic             out_last;

  logic [8:0]       line_buf [0:2*HLEN_MAX-1];
  logic             wr_en;
  logic [AW:0]      wr_addr;
  logic [AW:0]      rd_addr;
  logic [8:0]       wr_data;
  logic [8:0]       rd_data;
  logic             rd_ok;
  logic [8:0]       pix;

  // Edge detect only advances on input pixel strobes, so both edges already include ce_pix.
  assign hs_rise     = ce_pix & hs_in & ~hs_in_d;
  assign hs_fall     = ce_pix & ~hs_in & hs_in_d;
  assign hcnt_in_inc = (hcnt_in == CNT_MAX) ? CNT_MAX : hcnt_in + CNT_ONE;
  assign out_last    = ({1'b0, hcnt_out} + {1'b0, CNT_ONE}) >= {1'b0, hlen};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_in_d <= 1'b0;
      hcnt_in <= '0;
      hlen    <= HLEN_RST;
      hs_w    <= HSW_RST;
      bank    <= 1'b0;
    end else if (ce_pix) begin
      hs_in_d <= hs_in;
      if (hs_rise) begin
        hlen    <= hcnt_in_inc;
        hcnt_in <= '0;
        bank    <= ~bank;
      end else begin
        hcnt_in <= hcnt_in_inc;
      end
      if (hs_fall) hs_w <= hcnt_in_inc;
    end
  end

  // Write uses the pre-update bank, so the pixel under the sync rise closes the old line.
  assign wr_en   = ce_pix & ~reset & (hcnt_in < BUF_LEN);
  assign wr_addr = {bank, hcnt_in[AW-1:0]};
  assign wr_data = hblank_in ? 9'd0 : {r_in, g_in, b_in};
  assign rd_addr = {~bank, hcnt_out[AW-1:0]};

  always_ff @(posedge clk_sys) begin
    if (wr_en) line_buf[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_sys) begin
    if (ce_pix2x) rd_data <= line_buf[rd_addr];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_out <= '0;
      line_odd <= 1'b0;
      rd_ok    <= 1'b0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
    end else if (ce_pix2x) begin
      if (hs_rise) begin
        hcnt_out <= '0;
        line_odd <= 1'b0;
      end else if (out_last) begin
        hcnt_out <= '0;
        line_odd <= ~line_odd;
      end else begin
        hcnt_out <= hcnt_out + CNT_ONE;
      end
      rd_ok  <= hcnt_out < BUF_LEN;
      hs_out <= hcnt_out < hs_w;
      if (hcnt_out == '0) vs_out <= vs_in;
    end
  end

  assign pix = rd_ok ? rd_data : 9'd0;

`ifdef SCANDBL_SCANLINES_EN
  logic scan_q;
  logic dim_q;

  // dim_q travels with the registered read data so the dimming lines up with its pixel.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      scan_q <= 1'b0;
      dim_q  <= 1'b0;
    end else if (ce_pix2x) begin
      if (hcnt_out == '0) scan_q <= scanlines;
      dim_q <= line_odd & ((hcnt_out == '0) ? scanlines : scan_q);
    end
  end

  assign r_out = dim_q ? {1'b0, pix[8:7]} : pix[8:6];
  assign g_out = dim_q ? {1'b0, pix[5:4]} : pix[5:3];
  assign b_out = dim_q ? {1'b0, pix[2:1]} : pix[2:0];
`else
  logic unused_scanlines;
  assign unused_scanlines = scanlines;

  assign r_out = pix[8:6];
  assign g_out = pix[5:3];
  assign b_out = pix[2:0];
`endif

endmodule

// File: tb/tb_spectrum_scandoubler.sv
// Bench for spectrum_scandoubler: line-level stimulus table plus a pixel-accurate reference model
// built from line snapshots and output-position arithmetic.
module tb_spectrum_scandoubler;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic       ce_pix2x = 1'b0;
  logic       hs_in = 1'b0;
  logic       vs_in = 1'b0;
  logic       hblank_in = 1'b0;
  logic [2:0] r_in = 3'd0;
  logic [2:0] g_in = 3'd0;
  logic [2:0] b_in = 3'd0;
  logic       scanlines = 1'b0;
  logic       hs_out;
  logic       vs_out;
  logic [2:0] r_out;
  logic [2:0] g_out;
  logic [2:0] b_out;

`ifdef SCANDBL_SCANLINES_EN
  localparam bit DIM_EN = 1'b1;
`else
  localparam bit DIM_EN = 1'b0;
`endif

  spectrum_scandoubler dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .ce_pix2x  (ce_pix2x),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .hblank_in (hblank_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .scanlines (scanlines),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int len;
    int hsw;
    int blo;
    int bhi;
    int pat;
    bit scan;
    bit vs;
    int nlines;
    int exp_period;
    int exp_hi;
  } vec_t;

  vec_t vecs[8];

  int n_tests = 0;
  int n_fail = 0;
  int ph = 0;

  // Reference model state: captured line, displayed line, output position since line start.
  logic [8:0] cur_line [512];
  logic [8:0] disp_line [512];
  bit         disp_ok;
  int         in_idx;
  int         hlen_m;
  int         hsw_m;
  int         n_out;
  bit         prev_hs;
  bit         scan_cur;
  logic [8:0] exp_pix;
  bit         pix_known;
  bit         exp_hs;
  bit         exp_vs;

  // Output sync statistics, in output pixels.
  bit mon_prev;
  int mon_cnt;
  int mon_hi;
  int last_period;
  int last_hi;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int a;
    int copy;
    logic [8:0] px;
    bit rise;
    bit fall;
    if (reset) begin
      in_idx    = 0;
      hlen_m    = 448;
      hsw_m     = 32;
      n_out     = 0;
      disp_ok   = 1'b0;
      prev_hs   = 1'b0;
      scan_cur  = 1'b0;
      exp_pix   = 9'd0;
      pix_known = 1'b1;
      exp_hs    = 1'b0;
      exp_vs    = 1'b0;
      mon_prev  = 1'b0;
      mon_cnt   = 0;
      check("reset_hs", int'(hs_out), 0);
      check("reset_vs", int'(vs_out), 0);
      check("reset_pix", int'({r_out, g_out, b_out}), 0);
      return;
    end
    if (ce_pix2x) begin
      a    = n_out % hlen_m;
      copy = n_out / hlen_m;
      if (a == 0) begin
        exp_vs   = vs_in;
        scan_cur = scanlines;
      end
      exp_hs    = a < hsw_m;
      pix_known = disp_ok || (a >= 512);
      px        = (a < 512) ? disp_line[a] : 9'd0;
      if (DIM_EN && scan_cur && (copy % 2 == 1))
        px = {1'b0, px[8:7], 1'b0, px[5:4], 1'b0, px[2:1]};
      exp_pix = px;
      n_out++;
      check("hs_out", int'(hs_out), int'(exp_hs));
      check("vs_out", int'(vs_out), int'(exp_vs));
      if (pix_known) check("pixel", int'({r_out, g_out, b_out}), int'(exp_pix));
      if (hs_out && !mon_prev) begin
        last_period = mon_cnt;
        mon_cnt = 1;
        mon_hi = 1;
      end else begin
        mon_cnt++;
        if (hs_out) mon_hi++;
      end
      if (!hs_out && mon_prev) last_hi = mon_hi;
      mon_prev = hs_out;
    end
    if (ce_pix) begin
      rise = hs_in && !prev_hs;
      fall = !hs_in && prev_hs;
      prev_hs = hs_in;
      if (in_idx < 512) cur_line[in_idx] = hblank_in ? 9'd0 : {r_in, g_in, b_in};
      if (fall) hsw_m = sat(in_idx + 1);
      if (rise) begin
        hlen_m    = sat(in_idx + 1);
        disp_line = cur_line;
        disp_ok   = 1'b1;
        in_idx    = 0;
        n_out     = 0;
      end else begin
        in_idx = sat(in_idx + 1);
      end
    end
  endtask

  task automatic tick();
    ce_pix2x = (ph % 2) == 0;
    ce_pix   = (ph % 4) == 0;
    ph++;
    @(posedge clk_sys);
    #1;
    model_step();
  endtask

  // One input line: sync rises on the last pixel and stays high for hsw pixels in total.
  task automatic drive_line(input int len, input int hsw, input int blo, input int bhi,
                            input int pat, input bit scan, input bit vs, input int rst_at);
    logic [8:0] pv;
    for (int p = 0; p < len; p++) begin
      hs_in     = (p < hsw - 1) || (p == len - 1);
      hblank_in = (p >= blo) && (p <= bhi);
      case (pat)
        0:       pv = 9'(p);
        1:       pv = 9'($urandom_range(0, 511));
        default: pv = 9'h1ff;
      endcase
      {r_in, g_in, b_in} = pv;
      scanlines = scan;
      vs_in     = vs;
      for (int t = 0; t < 4; t++) begin
        reset = (p == rst_at) && (t == 0);
        tick();
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{len: 448, hsw: 32, blo: -1,  bhi: -1,  pat: 0, scan: 0, vs: 0, nlines: 3, exp_period: 448, exp_hi: 32};
    vecs[1] = '{len: 456, hsw: 32, blo: -1,  bhi: -1,  pat: 1, scan: 0, vs: 0, nlines: 3, exp_period: 456, exp_hi: 32};
    vecs[2] = '{len: 448, hsw: 32, blo: 312, bhi: 419, pat: 0, scan: 0, vs: 0, nlines: 2, exp_period: 448, exp_hi: 32};
    vecs[3] = '{len: 448, hsw: 32, blo: -1,  bhi: -1,  pat: 2, scan: 1, vs: 0, nlines: 2, exp_period: 448, exp_hi: 32};
    vecs[4] = '{len: 448, hsw: 32, blo: -1,  bhi: -1,  pat: 1, scan: 0, vs: 1, nlines: 4, exp_period: 448, exp_hi: 32};
    vecs[5] = '{len: 448, hsw: 32, blo: -1,  bhi: -1,  pat: 1, scan: 0, vs: 0, nlines: 2, exp_period: 448, exp_hi: 32};
    vecs[6] = '{len: 300, hsw: 16, blo: -1,  bhi: -1,  pat: 1, scan: 1, vs: 0, nlines: 3, exp_period: 300, exp_hi: 16};
    vecs[7] = '{len: 520, hsw: 40, blo: 100, bhi: 130, pat: 1, scan: 0, vs: 0, nlines: 3, exp_period: 520, exp_hi: 40};

    last_period = 0;
    last_hi = 0;
    mon_hi = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < vecs[i].nlines; l++)
        drive_line(vecs[i].len, vecs[i].hsw, vecs[i].blo, vecs[i].bhi,
                   vecs[i].pat, vecs[i].scan, vecs[i].vs, -1);
      check($sformatf("period_v%0d", i), last_period, vecs[i].exp_period);
      check($sformatf("hs_width_v%0d", i), last_hi, vecs[i].exp_hi);
    end

    // Sync missing for well over 1023 input pixels, then normal lines again.
    drive_line(1532, 32, -1, -1, 1, 1'b0, 1'b0, -1);
    drive_line(448, 32, -1, -1, 1, 1'b0, 1'b0, -1);
    drive_line(448, 32, -1, -1, 0, 1'b0, 1'b0, -1);
    check("period_after_long", last_period, 448);

    // One-cycle reset in the middle of a line, then recovery.
    drive_line(448, 32, -1, -1, 1, 1'b0, 1'b0, 200);
    drive_line(448, 32, -1, -1, 1, 1'b1, 1'b0, -1);
    drive_line(448, 32, -1, -1, 2, 1'b1, 1'b0, -1);
    check("period_after_reset", last_period, 448);
    check("hs_width_after_reset", last_hi, 32);

    for (int i = 0; i < 16; i++) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
